clk_div_odd: RTL and testbench
==============================

Name: clk_div_odd

Overview:
- Divides an input clock by a fixed odd integer N and produces an output clock with exactly 50% duty cycle.
- Combines one rising-edge counter/flag with a falling-edge retimed copy of that flag.
- Sits in the clock-generation area and feeds slow-clock consumers (test/low-speed logic, not timing-critical trees).

Parameters:
- DIV, 3, odd division ratio N; legal values are odd and ≥3, anything else is an elaboration error.
- CNT_W, $clog2(DIV), counter width (derived; not overridden).

Ports:
- clk_in  input  1  source clock; all state is clocked by its rising edge except one falling-edge flop.
- rst_n   input  1  synchronous, active-low reset.
- clk_out output 1  divided clock, frequency clk_in/DIV, 50% duty.

Behaviour:
- Interface: one clock (clk_in); reset rst_n is synchronous and active-low.
- Constant HALF = (DIV-1)/2.
- Rising-edge counter cnt:
  - rst_n=0 at a rising edge: cnt ← DIV-1.
  - Otherwise cnt ← (cnt==DIV-1) ? 0 : cnt+1.
- Rising-edge flag q_pos:
  - rst_n=0: q_pos ← 0.
  - Otherwise q_pos ← (cnt_next < HALF), where cnt_next is the value cnt is loaded with at that edge.
- Falling-edge flag q_neg:
  - On the falling edge of clk_in, q_neg ← 0 if rst_n=0, else q_neg ← q_pos.
  - Reset is synchronous to the capturing edge.
- clk_out = q_pos | q_neg. Only registered signals feed the OR; there is no other combinational path to clk_out.
- Output timing:
  - q_pos is high for HALF input periods.
  - q_neg extends it by half a period.
  - clk_out is therefore high for DIV/2 periods and low for DIV/2 periods (DIV=3: 1.5 high / 1.5 low).
- Reset:
  - clk_out is 0 from the first reset edge pair (rising then falling) while rst_n=0.
- Release:
  - At the first rising edge sampling rst_n=1, cnt wraps to 0, q_pos rises, and clk_out rises at that edge.
  - The waveform is periodic from then on; there are no runt pulses after release.
- Reset asserted mid-period:
  - The next rising edge clears q_pos; the next falling edge clears q_neg.
  - clk_out goes low within one input period and stays low; it may truncate the current high phase.
- cnt never exceeds DIV-1; wrap-around is continuous.

Decomposition:
- No shared package is needed. HALF and CNT_W are local constants.
- Parameter legality is checked with an elaboration-time generate/assertion.
- Single module; no sub-module. The posedge counter is too small to justify one.

Test Plan:
- DIV=3, clk_in period 20 ns, rst_n low for 3 cycles then high → clk_out 0 during reset, rises at the first posedge with rst_n=1, then 30 ns high / 30 ns low, period 60 ns.
- DIV=5, same clock → clk_out 50 ns high / 50 ns low, period 100 ns, for ≥20 output periods; no glitches.
- DIV=7 → 70 ns high / 70 ns low; the measured duty cycle is exactly 50% at every edge.
- Reset asserted while clk_out is high (DIV=5) → clk_out low within 20 ns and held low; after release, the first rising edge is aligned to the first posedge sampling rst_n=1.
- Count clk_in rising edges between consecutive clk_out rising edges for DIV∈{3,5,9} → always exactly DIV.
- Elaborate with DIV=4 or DIV=1 → elaboration error.

Source files
------------

// File: rtl/clk_div_odd.sv
// Odd-ratio clock divider with exact 50% duty: a rising-edge counter/flag
// whose pulse is stretched by half an input period through a falling-edge copy.
module clk_div_odd #(
    parameter int DIV = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
);

    localparam int CNT_W = $clog2(DIV);
    localparam int HALF  = (DIV - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);

    // Even or too-small ratios cannot give a symmetric waveform with this scheme.
    generate
        if ((DIV < 3) || ((DIV % 2) == 0)) begin : g_bad_div
            $error("clk_div_odd: DIV must be odd and >= 3");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             q_pos_reg;
    logic             q_neg_reg;

    always_comb begin
        cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
    end

    // Reset parks the counter at its last value so release wraps straight to 0
    // and the first output edge coincides with the first released rising edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_reg   <= CNT_MAX;
            q_pos_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            q_pos_reg <= (cnt_next < HALF_CNT);
        end
    end

    always_ff @(negedge clk_in) begin
        if (!rst_n) begin
            q_neg_reg <= 1'b0;
        end else begin
            q_neg_reg <= q_pos_reg;
        end
    end

    assign clk_out = q_pos_reg | q_neg_reg;

endmodule

// File: tb/tb_clk_div_odd.sv
// Bench for clk_div_odd: four ratios side by side, random reset pulses,
// half-period reference model plus edge-timing measurements.
`timescale 1ns/1ps
module tb_clk_div_odd;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] outs;

    always #10 clk_in = ~clk_in;

    clk_div_odd #(.DIV(3)) u_div3 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(outs[0]));
    clk_div_odd #(.DIV(5)) u_div5 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(outs[1]));
    clk_div_odd #(.DIV(7)) u_div7 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(outs[2]));
    clk_div_odd #(.DIV(9)) u_div9 (.clk_in(clk_in), .rst_n(rst_n), .clk_out(outs[3]));

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Model state: half-period index since release and length of current reset run.
    int     h        = 0;
    int     rst_cnt  = 0;
    bit     released = 1'b0;
    bit     prev_out  [4];
    longint last_rise [4];
    int     pe_cnt    [4];

    function automatic int div_of(input int i);
        case (i)
            0:       return 3;
            1:       return 5;
            2:       return 7;
            default: return 9;
        endcase
    endfunction

    // Output is high for the first DIV half-periods of every 2*DIV.
    function automatic int model_out(input int d, input int hh);
        return ((hh % (2 * d)) < d) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int req);
        cmp_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s div=%0d t=%0t actual=%0d required=%0d",
                     name, div_of(idx), $time, act, req);
        end
    endtask

    task automatic sample_half(input bit at_pos);
        int o;
        int d;
        for (int i = 0; i < 4; i++) begin
            o = int'(outs[i]);
            d = div_of(i);
            if (released)
                check("model", i, o, model_out(d, h));
            else if ((rst_cnt >= 2) || (!at_pos && (rst_cnt >= 1)))
                check("reset_low", i, o, 0);

            if (released) begin
                if ((o == 1) && !prev_out[i]) begin
                    if (last_rise[i] >= 0) begin
                        check("period_ns", i, int'($time - last_rise[i]), 20 * d);
                        check("edges_per_period", i, pe_cnt[i], d);
                    end
                    last_rise[i] = $time;
                    pe_cnt[i]    = 0;
                end else if ((o == 0) && prev_out[i] && (last_rise[i] >= 0)) begin
                    check("high_ns", i, int'($time - last_rise[i]), 10 * d);
                end
            end else begin
                last_rise[i] = -1;
            end
            prev_out[i] = (o == 1);
        end
    endtask

    initial begin : compare
        for (int i = 0; i < 4; i++) begin
            prev_out[i]  = 1'b0;
            last_rise[i] = -1;
            pe_cnt[i]    = 0;
        end
        forever begin
            @(posedge clk_in);
            if (!rst_n) begin
                rst_cnt++;
                released = 1'b0;
            end else begin
                if (!released) begin
                    h        = 0;
                    released = 1'b1;
                end else begin
                    h++;
                end
                rst_cnt = 0;
            end
            for (int i = 0; i < 4; i++) pe_cnt[i]++;
            #1;
            sample_half(1'b1);
            @(negedge clk_in);
            if (released) h++;
            #1;
            sample_half(1'b0);
        end
    end

    initial begin : stimulus
        int w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        for (int i = 0; i < 4; i++) check("reset_lit", i, int'(outs[i]), 0);
        #1 rst_n = 1'b1;
        @(posedge clk_in);
        #2;
        for (int i = 0; i < 4; i++) check("release_lit", i, int'(outs[i]), 1);

        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(30, 120)) @(negedge clk_in);
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk_in);
            #2 rst_n = 1'b1;
        end

        // Directed: assert reset while the DIV=5 output is high.
        repeat (30) @(negedge clk_in);
        w = 0;
        #1;
        while ((outs[1] !== 1'b1) && (w < 50)) begin
            @(negedge clk_in);
            #1;
            w++;
        end
        check("wait_div5_high", 1, int'(outs[1]), 1);
        #1 rst_n = 1'b0;
        @(negedge clk_in);
        #1;
        check("assert_low_lit", 1, int'(outs[1]), 0);
        repeat (2) @(negedge clk_in);
        #2 rst_n = 1'b1;
        @(posedge clk_in);
        #2;
        for (int i = 0; i < 4; i++) check("rerelease_lit", i, int'(outs[i]), 1);

        repeat (60) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
